serial_deserializer: RTL
========================

Name: serial_deserializer

Overview:
Receive side of the team's MSB-first serial word link: accepts a frame start, then N bit strobes on a single serial line, and assembles each frame into a parallel word. Each completed word is presented on a one-entry output buffer with a valid/ready handshake. An internal bit counter tracks frame position. A sticky overrun flag reports bits or starts lost while a completed word is stalled.

Parameters:
N, 5, word width in bits; N >= 2.
CW, 3, bit-counter width; N must not exceed 2^CW - 1.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle frame-start pulse
sen  input  1  bit strobe; sin is valid in this cycle
sin  input  1  serial data, MSB first
dout  output  N  assembled word; stable while dvalid=1
dvalid  output  1  dout holds an unconsumed word
dready  input  1  consumer accepts dout when dvalid & dready
busy  output  1  high in SHIFT or HOLD
ovr  output  1  sticky overrun flag
clr_ovr  input  1  synchronous clear of ovr
perr  output  1  parity error qualifier for dout; see Optional Feature

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; shift register=0; count=0; dout=0; dvalid=0; ovr=0; perr=0; busy=0.
- FSM states are IDLE, SHIFT and HOLD.
- IDLE:
  - start=1: go to SHIFT, clear shift register and count.
  - sen in the same cycle as start is ignored; the first bit must arrive after start.
  - sen without start is ignored and does not set ovr.
- SHIFT, on sen=1:
  - shreg <= {shreg[N-2:0], sin}; count <= count+1.
  - The last bit is the strobe with count==N-1.
- SHIFT, on the last bit:
  - If the buffer is free (dvalid=0, or dvalid & dready this cycle), then next cycle dout <= completed word, dvalid=1, state=IDLE.
  - Otherwise state=HOLD with the completed word kept in shreg.
- Latency: last sen at cycle k gives dvalid=1 at cycle k+1.
- start=1 in SHIFT aborts the current frame and restarts it: count=0, shreg=0, ovr is unaffected. start has priority over sen in the same cycle.
- HOLD:
  - When the buffer frees (dvalid & dready), next cycle dout <= shreg, dvalid=1, state=IDLE.
  - Any sen or start in HOLD is dropped and sets ovr.
- Output handshake:
  - dvalid falls the cycle after dvalid & dready, unless a new word loads in that same edge; in that case dvalid stays 1 and dout updates.
  - dout must not change while dvalid=1 and dready=0.
- ovr is set by HOLD drops and cleared only by clr_ovr or reset. If clr_ovr and a set event occur in the same cycle, set wins.
- Counter wrap cannot occur: count is cleared on frame completion and never exceeds N-1 (N in parity mode).
- busy = (state != IDLE).

Optional Feature:
- Macro: SERIAL_DESER_PARITY_EN.
- Enabled:
  - Each frame carries N+1 bits: N data bits, then one even-parity bit.
  - The frame completes on the strobe with count==N.
  - perr loads with dout and is 1 when the XOR of the data bits and the parity bit is 1.
  - perr is valid only while dvalid=1.
  - Latency is unchanged relative to the final strobe.
- Disabled: frame length is N; perr is tied to 0.

Decomposition:
- Shared package serial_link_pkg holds:
  - state typedef {IDLE, SHIFT, HOLD} with 2-bit encoding;
  - default N and CW constants;
  - FRAME_LEN constant, equal to N+1 under the macro and N otherwise.
- One sub-module: deser_bit_counter, a CW-bit counter with synchronous clear, enable and terminal-count output (count==FRAME_LEN-1). It is instantiated once.
- Shift register, FSM and output buffer stay in the top module.

Test Plan:
- Basic frame (N=5, dready=1): start; sen with sin=1,0,1,1,0 → dout=5'b10110 and dvalid=1 one cycle after the 5th sen; busy low again.
- Backpressure (dready=0): complete frame 5'b10110, then start plus frame 5'b01001 → second frame ends in HOLD; dout stays 5'b10110. Raise dready → next cycle dout=5'b01001, dvalid=1.
- Overrun: while in HOLD, pulse sen twice → ovr=1 and dout unchanged. clr_ovr → ovr=0. clr_ovr coincident with a HOLD sen → ovr=1.
- Abort: start, 3 bits 1,1,1, start again, then 0,0,0,0,1 → dout=5'b00001.
- Reset mid-frame: rst low after 2 bits → all outputs 0 asynchronously; after release, a full frame 5'b11111 → dout=5'b11111.
- Parity mode (SERIAL_DESER_PARITY_EN): data 1,0,1,1,0 with parity 1 → perr=0. Same data with parity 0 → perr=1.

Source files
------------

// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared types and sizing for the MSB-first serial word link.
// SERIAL_DESER_PARITY_EN adds a trailing even-parity bit to every frame.
package serial_link_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} state_t;
  localparam int N_DEF = 5;
  localparam int CW_DEF = 3;
  function automatic int frame_len(input int n);
`ifdef SERIAL_DESER_PARITY_EN
    return n + 1;
`else
    return n;
`endif
  endfunction
  localparam int FRAME_LEN = frame_len(N_DEF);
endpackage

// File: rtl/deser_bit_counter.sv
// deser_bit_counter: frame-position counter with sync clear, enable and terminal count.
module deser_bit_counter #(
  parameter int CW = 3,
  parameter int LEN = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= i_clr ? '0 : i_en ? r_cnt + 1'b1 : r_cnt;
  assign o_tc = r_cnt == CW'(LEN - 1);
endmodule

// File: rtl/serial_deserializer.sv
// serial_deserializer: assembles MSB-first serial frames into words behind a one-entry valid/ready buffer.
// SERIAL_DESER_PARITY_EN: frames carry a trailing even-parity bit reported on perr.
module serial_deserializer
  import serial_link_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sen,
  input  logic         sin,
  output logic [N-1:0] dout,
  output logic         dvalid,
  input  logic         dready,
  output logic         busy,
  output logic         ovr,
  input  logic         clr_ovr,
  output logic         perr
);
  localparam int L = frame_len(N);
  state_t r_state;
  logic [L-1:0] r_shreg;
  logic [N-1:0] r_dout;
  logic r_dvalid, r_ovr;
  logic w_tc, w_free, w_shift, w_last, w_load, w_restart, w_clr, w_set_ovr;
  logic [L-1:0] w_next, w_src;
  assign w_free = !r_dvalid || dready;
  assign w_shift = (r_state == SHIFT) && sen && !start;
  assign w_last = w_shift && w_tc;
  assign w_next = {r_shreg[L-2:0], sin};
  assign w_load = (w_last || r_state == HOLD) && w_free;
  assign w_src = (r_state == HOLD) ? r_shreg : w_next;
  assign w_restart = start && r_state != HOLD;
  assign w_clr = w_restart || w_last;
  assign w_set_ovr = (r_state == HOLD) && (sen || start);
  deser_bit_counter #(.CW(CW), .LEN(L)) u_cnt (
    .clk(clk), .rst_n(rst), .i_clr(w_clr), .i_en(w_shift), .o_tc(w_tc)
  );
  // A stalled word stays in r_shreg while in HOLD until the buffer frees.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_dout <= '0;
      r_dvalid <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_state <= w_load ? IDLE : w_last ? HOLD : w_restart ? SHIFT : r_state;
      r_shreg <= w_restart ? '0 : w_shift ? w_next : r_shreg;
      r_dout <= w_load ? w_src[L-1 -: N] : r_dout;
      r_dvalid <= w_load || (r_dvalid && !dready);
      r_ovr <= w_set_ovr || (r_ovr && !clr_ovr);
    end
`ifdef SERIAL_DESER_PARITY_EN
  logic r_perr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_perr <= 1'b0;
    else r_perr <= w_load ? ^w_src : r_perr;
  assign perr = r_perr;
`else
  assign perr = 1'b0;
`endif
  assign dout = r_dout;
  assign dvalid = r_dvalid;
  assign ovr = r_ovr;
  assign busy = r_state != IDLE;
endmodule
